// File: rtl/bh_pkg.sv
// Shared types and defaults for the black-hole renderer: palette and shade enums,
// colour-level helpers and the default radius constants.
package bh_pkg;

  localparam int CX_DEF          = 320;
  localparam int CY_DEF          = 240;
  localparam int COLOR_BITS_DEF  = 2;
  localparam int SHADOW_R2_DEF   = 7225;
  localparam int BELT_IN_R2_DEF  = 10000;
  localparam int BELT_OUT_R2_DEF = 85000;
  localparam int HALO_IN_R2_DEF  = 5000;
  localparam int HALO_OUT_R2_DEF = 22000;
  localparam int FLAT_SHIFT_DEF  = 4;
  localparam int DRIFT_MAX_DEF   = 8;

  typedef enum logic [1:0] {PAL_RED_YELLOW, PAL_BLUE_CYAN, PAL_GREEN_WHITE, PAL_GREY} palette_e;
  typedef enum logic [1:0] {BASE, ACCENT, DIM} shade_e;
  typedef enum logic [1:0] {LV_OFF, LV_DIM, LV_MID, LV_FULL} level_e;

  typedef struct packed {
    level_e r;
    level_e g;
    level_e b;
  } rgb_lvl_t;

  // FULL = all ones, MID = MSB only, DIM = LSB only, at the given channel width.
  function automatic int unsigned level_val(level_e lv, int unsigned bits);
    case (lv)
      LV_FULL: return (32'd1 << bits) - 32'd1;
      LV_MID:  return 32'd1 << (bits - 1);
      LV_DIM:  return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic rgb_lvl_t pal_lookup(palette_e pal, shade_e sh);
    case (pal)
      PAL_RED_YELLOW:
        case (sh)
          ACCENT:  return '{LV_FULL, LV_MID, LV_OFF};
          DIM:     return '{LV_DIM, LV_OFF, LV_OFF};
          default: return '{LV_FULL, LV_OFF, LV_OFF};
        endcase
      PAL_BLUE_CYAN:
        case (sh)
          ACCENT:  return '{LV_OFF, LV_FULL, LV_FULL};
          DIM:     return '{LV_OFF, LV_OFF, LV_DIM};
          default: return '{LV_OFF, LV_OFF, LV_FULL};
        endcase
      PAL_GREEN_WHITE:
        case (sh)
          ACCENT:  return '{LV_FULL, LV_FULL, LV_FULL};
          DIM:     return '{LV_OFF, LV_DIM, LV_OFF};
          default: return '{LV_OFF, LV_FULL, LV_OFF};
        endcase
      default:
        case (sh)
          ACCENT:  return '{LV_FULL, LV_FULL, LV_FULL};
          DIM:     return '{LV_DIM, LV_DIM, LV_DIM};
          default: return '{LV_MID, LV_MID, LV_MID};
        endcase
    endcase
  endfunction

endpackage

// File: rtl/bh_render_pipe_if.sv
// Video bus between the timing generator, the renderer and the PMOD output mux.
interface bh_render_pipe_if #(
  parameter int COLOR_BITS = 2
);
  logic                  de_in;
  logic                  hsync_in;
  logic                  vsync_in;
  logic [9:0]            x_in;
  logic [9:0]            y_in;
  logic                  de_out;
  logic                  hsync_out;
  logic                  vsync_out;
  logic [COLOR_BITS-1:0] r_out;
  logic [COLOR_BITS-1:0] g_out;
  logic [COLOR_BITS-1:0] b_out;

  modport master (
    output de_in, hsync_in, vsync_in, x_in, y_in,
    input  de_out, hsync_out, vsync_out, r_out, g_out, b_out
  );

  modport slave (
    input  de_in, hsync_in, vsync_in, x_in, y_in,
    output de_out, hsync_out, vsync_out, r_out, g_out, b_out
  );
endinterface

// File: rtl/bh_anim_ctrl.sv
// Per-frame animation state: frame tick on vsync rise, frame counter, texture phase
// and the horizontal centre drift that bounces between +/-DRIFT_MAX.
module bh_anim_ctrl
  import bh_pkg::*;
#(
  parameter int DRIFT_MAX = DRIFT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync_in,
  input  logic              pause,
  input  logic              reverse,
  input  logic [2:0]        speed,
  input  logic              drift_en,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        phase,
  output logic signed [8:0] x_off
);

  localparam logic signed [8:0] DMAX = 9'(DRIFT_MAX);

  logic              vsync_q;
  logic              drift_up;
  logic              tick;
  logic signed [8:0] off_nxt;

  assign tick    = vsync_in & ~vsync_q;
  assign off_nxt = drift_up ? x_off + 9'sd1 : x_off - 9'sd1;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q   <= 1'b1;
      frame_cnt <= '0;
      phase     <= '0;
      x_off     <= '0;
      drift_up  <= 1'b1;
    end else begin
      vsync_q <= vsync_in;
      if (tick) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (!pause)
          phase <= reverse ? phase - {5'd0, speed} : phase + {5'd0, speed};
        if (!drift_en) begin
          x_off    <= '0;
          drift_up <= 1'b1;
        end else begin
          x_off <= off_nxt;
          if (off_nxt == DMAX)
            drift_up <= 1'b0;
          else if (off_nxt == -DMAX)
            drift_up <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bh_render_pipe.sv
// Three-stage black-hole renderer: centre offsets, squares, then radius metrics,
// region priority, texture and palette, with syncs delay-matched to the colour.
module bh_render_pipe
  import bh_pkg::*;
#(
  parameter int CX          = CX_DEF,
  parameter int CY          = CY_DEF,
  parameter int COLOR_BITS  = COLOR_BITS_DEF,
  parameter int SHADOW_R2   = SHADOW_R2_DEF,
  parameter int BELT_IN_R2  = BELT_IN_R2_DEF,
  parameter int BELT_OUT_R2 = BELT_OUT_R2_DEF,
  parameter int HALO_IN_R2  = HALO_IN_R2_DEF,
  parameter int HALO_OUT_R2 = HALO_OUT_R2_DEF,
  parameter int FLAT_SHIFT  = FLAT_SHIFT_DEF,
  parameter int DRIFT_MAX   = DRIFT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  bh_render_pipe_if.slave  vid,
  input  logic             pause,
  input  logic             reverse,
  input  logic [2:0]       speed,
  input  logic             drift_en,
  input  logic [1:0]       palette,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       phase
);

  localparam logic signed [10:0] CX_S = 11'(CX);
  localparam logic signed [10:0] CY_S = 11'(CY);

  logic signed [8:0]  x_off;
  logic signed [10:0] cx;

  bh_anim_ctrl #(.DRIFT_MAX(DRIFT_MAX)) u_anim (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync_in (vid.vsync_in),
    .pause    (pause),
    .reverse  (reverse),
    .speed    (speed),
    .drift_en (drift_en),
    .frame_cnt(frame_cnt),
    .phase    (phase),
    .x_off    (x_off)
  );

  assign cx = CX_S + {{2{x_off[8]}}, x_off};

  logic               de_s1, hs_s1, vs_s1, de_s2, hs_s2, vs_s2;
  logic signed [10:0] dx_s1, dy_s1;
  logic signed [21:0] dx_w, dy_w;
  logic [21:0]        dx2_s2, dy2_s2;
  logic               front_s2;

  assign dx_w = {{11{dx_s1[10]}}, dx_s1};
  assign dy_w = {{11{dy_s1[10]}}, dy_s1};

  // NOTE: datapath registers carry no reset; de travels beside them and masks their contents at the output.
  always_ff @(posedge clk) begin
    dx_s1    <= $signed({1'b0, vid.x_in}) - cx;
    dy_s1    <= $signed({1'b0, vid.y_in}) - CY_S;
    dx2_s2   <= $unsigned(dx_w * dx_w);
    dy2_s2   <= $unsigned(dy_w * dy_w);
    front_s2 <= dy_s1 > 11'sd4;
  end

  logic [21:0] r2c, r2f;
  logic        shadow, belt, halo, lit;
  logic [7:0]  bt, ht, tex;
  shade_e      shade;
  rgb_lvl_t    lvl;

  assign r2c    = dx2_s2 + dy2_s2;
  assign r2f    = dx2_s2 + (dy2_s2 << FLAT_SHIFT);
  assign shadow = r2c < 22'(SHADOW_R2);
  assign belt   = (r2f >= 22'(BELT_IN_R2)) && (r2f <= 22'(BELT_OUT_R2));
  assign halo   = (r2c >= 22'(HALO_IN_R2)) && (r2c <= 22'(HALO_OUT_R2));
  assign bt     = r2f[15:8] - phase;
  assign ht     = r2c[13:6] - phase;

  // Front belt occludes the shadow; the back belt is hidden behind it.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    lit = 1'b1;
    tex = '0;
    if (belt && front_s2)
      tex = bt;
    else if (shadow)
      lit = 1'b0;
    else if (belt)
      tex = bt;
    else if (halo)
      tex = ht;
    else
      lit = 1'b0;
  end

  assign shade = tex[4] ? DIM : (tex[2] ? ACCENT : BASE);
  assign lvl   = pal_lookup(palette_e'(palette), shade);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_s1         <= 1'b0;
      hs_s1         <= 1'b1;
      vs_s1         <= 1'b1;
      de_s2         <= 1'b0;
      hs_s2         <= 1'b1;
      vs_s2         <= 1'b1;
      vid.de_out    <= 1'b0;
      vid.hsync_out <= 1'b1;
      vid.vsync_out <= 1'b1;
      vid.r_out     <= '0;
      vid.g_out     <= '0;
      vid.b_out     <= '0;
    end else begin
      de_s1         <= vid.de_in;
      hs_s1         <= vid.hsync_in;
      vs_s1         <= vid.vsync_in;
      de_s2         <= de_s1;
      hs_s2         <= hs_s1;
      vs_s2         <= vs_s1;
      vid.de_out    <= de_s2;
      vid.hsync_out <= hs_s2;
      vid.vsync_out <= vs_s2;
      vid.r_out     <= (de_s2 && lit) ? COLOR_BITS'(level_val(lvl.r, COLOR_BITS)) : '0;
      vid.g_out     <= (de_s2 && lit) ? COLOR_BITS'(level_val(lvl.g, COLOR_BITS)) : '0;
      vid.b_out     <= (de_s2 && lit) ? COLOR_BITS'(level_val(lvl.b, COLOR_BITS)) : '0;
    end
  end

endmodule

// File: tb/tb_bh_render_pipe.sv
// Bench for bh_render_pipe: directed pixels, random pixel streams against a geometric
// reference model, animation/drift control sequences, a reduced frame and mid-line reset.
module tb_bh_render_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pause, reverse, drift_en;
  logic [2:0]  speed;
  logic [1:0]  palette;
  logic [15:0] frame_cnt;
  logic [7:0]  phase;

  always #5 clk = ~clk;

  bh_render_pipe_if #(.COLOR_BITS(2)) vid ();

  bh_render_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vid      (vid),
    .pause    (pause),
    .reverse  (reverse),
    .speed    (speed),
    .drift_en (drift_en),
    .palette  (palette),
    .frame_cnt(frame_cnt),
    .phase    (phase)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: frame count, phase and number of drift ticks since enable.
  int m_frame, m_phase, m_dn;
  bit m_vs_prev = 1'b1;

  // Drift traces a triangle wave of amplitude 8 and period 32 ticks.
  function automatic int m_off();
    int m;
    m = m_dn % 32;
    if (m <= 8) return m;
    if (m <= 24) return 16 - m;
    return m - 32;
  endfunction

  function automatic void model_tick();
    m_frame = (m_frame + 1) & 16'hFFFF;
    if (!pause) m_phase = (m_phase + (reverse ? -int'(speed) : int'(speed))) & 255;
    m_dn = drift_en ? m_dn + 1 : 0;
  endfunction

  function automatic logic [5:0] ref_rgb(int x, int y, int off, int ph, int pal);
    int dx, dy, r2c, r2f, t;
    bit belt, halo;
    logic [5:0] base, acc, dimc;
    dx   = x - (320 + off);
    dy   = y - 240;
    r2c  = (dx * dx + dy * dy) % 4194304;
    r2f  = (dx * dx + 16 * dy * dy) % 4194304;
    belt = (r2f >= 10000) && (r2f <= 85000);
    halo = (r2c >= 5000) && (r2c <= 22000);
    if (belt && dy > 4) t = (r2f / 256 - ph) & 255;
    else if (r2c < 7225) return 6'b0;
    else if (belt) t = (r2f / 256 - ph) & 255;
    else if (halo) t = (r2c / 64 - ph) & 255;
    else return 6'b0;
    case (pal)
      0: begin base = 6'b11_00_00; acc = 6'b11_10_00; dimc = 6'b01_00_00; end
      1: begin base = 6'b00_00_11; acc = 6'b00_11_11; dimc = 6'b00_00_01; end
      2: begin base = 6'b00_11_00; acc = 6'b11_11_11; dimc = 6'b00_01_00; end
      default: begin base = 6'b10_10_10; acc = 6'b11_11_11; dimc = 6'b01_01_01; end
    endcase
    if ((t & 16) != 0) return dimc;
    if ((t & 4) != 0) return acc;
    return base;
  endfunction

  task automatic drive(bit de, bit hs, bit vs, int x, int y);
    vid.de_in    = de;
    vid.hsync_in = hs;
    vid.vsync_in = vs;
    vid.x_in     = 10'(x);
    vid.y_in     = 10'(y);
    if (vs && !m_vs_prev && rst_n) model_tick();
    m_vs_prev = vs;
  endtask

  task automatic do_tick();
    @(negedge clk) drive(0, 1, 0, 0, 0);
    @(negedge clk) drive(0, 1, 1, 0, 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1, 1, 0, 0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    m_frame   = 0;
    m_phase   = 0;
    m_dn      = 0;
    m_vs_prev = 1'b1;
  endtask

  task automatic one_pixel(string tag, int x, int y, logic [5:0] exp);
    @(negedge clk) drive(1, 1, 1, x, y);
    @(negedge clk) drive(0, 1, 1, 0, 0);
    repeat (2) @(negedge clk);
    check(tag, {vid.de_out, vid.r_out, vid.g_out, vid.b_out}, {1'b1, exp});
  endtask

  int s_x[512], s_y[512];
  bit s_de[512], s_hs[512], s_vs[512];

  task automatic run_stream(string tag, int n);
    logic [8:0] exp_q[$];
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      if (i >= 3)
        check(tag, {vid.de_out, vid.hsync_out, vid.vsync_out, vid.r_out, vid.g_out, vid.b_out},
              exp_q.pop_front());
      if (i < n) begin
        exp_q.push_back({s_de[i], s_hs[i], s_vs[i],
                         s_de[i] ? ref_rgb(s_x[i], s_y[i], m_off(), m_phase, int'(palette)) : 6'b0});
        drive(s_de[i], s_hs[i], s_vs[i], s_x[i], s_y[i]);
      end else begin
        drive(0, 1, 1, 0, 0);
      end
    end
  endtask

  task automatic fill_random(int n);
    for (int i = 0; i < n; i++) begin
      s_de[i] = $urandom_range(0, 7) != 0;
      s_hs[i] = 1'($urandom_range(0, 1));
      s_vs[i] = 1'b1;
      s_x[i]  = int'($urandom_range(0, 799));
      s_y[i]  = int'($urandom_range(0, 524));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int got_off;
    int n;
    pause = 0; reverse = 0; speed = 0; drift_en = 0; palette = 0;
    drive(0, 1, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_vid", {vid.de_out, vid.hsync_out, vid.vsync_out, vid.r_out, vid.g_out, vid.b_out},
          9'b0_1_1_000000);
    check("rst_frame", frame_cnt, 0);
    check("rst_phase", phase, 0);
    got_off = dut.x_off;
    check("rst_off", got_off, 0);
    rst_n = 1'b1;
    m_frame = 0; m_phase = 0; m_dn = 0;

    one_pixel("centre_shadow", 320, 240, 6'b00_00_00);
    one_pixel("halo_gap_pal0", 320, 340, 6'b01_00_00);
    one_pixel("belt_acc_pal0", 420, 250, 6'b11_10_00);
    palette = 1;
    one_pixel("belt_acc_pal1", 420, 250, 6'b00_11_11);

    for (int p = 0; p < 4; p++) begin
      palette = 2'(p);
      fill_random(48);
      run_stream("rand_pix", 48);
    end

    speed = 2;
    repeat (10) do_tick();
    check("phase_spd2", phase, 20);
    check("frame_10", frame_cnt, 32'(m_frame));
    palette = 2;
    fill_random(40);
    run_stream("rand_ph20", 40);
    pause = 1;
    repeat (5) do_tick();
    check("phase_pause", phase, 20);
    check("frame_pause", frame_cnt, 15);
    pause = 0; reverse = 1; speed = 4;
    repeat (5) do_tick();
    check("phase_rev0", phase, 0);
    speed = 1;
    do_tick();
    check("phase_wrap", phase, 255);
    reverse = 0; speed = 3;
    repeat (7) do_tick();
    check("phase_model", phase, 32'(m_phase));
    palette = 3;
    fill_random(40);
    run_stream("rand_ph", 40);

    speed = 0; drift_en = 1; palette = 0;
    for (int k = 1; k <= 30; k++) begin
      do_tick();
      got_off = dut.x_off;
      check("drift_off", got_off, m_off());
      if (k == 9) begin
        check("drift_k9", got_off, 7);
        fill_random(40);
        run_stream("rand_drift", 40);
        got_off = dut.x_off;
        check("drift_hold", got_off, 7);
      end
    end
    drift_en = 0;
    do_tick();
    got_off = dut.x_off;
    check("drift_off0", got_off, 0);

    // Reduced frame: 40 clocks per line, 12 lines, syncs active low.
    palette = 3;
    n = 0;
    for (int v = 0; v < 12; v++)
      for (int h = 0; h < 40; h++) begin
        s_de[n] = (h < 32) && (v < 8);
        s_hs[n] = !((h >= 34) && (h < 38));
        s_vs[n] = !((v == 9) || (v == 10));
        s_x[n]  = h * 20;
        s_y[n]  = v * 60;
        n++;
      end
    run_stream("frame_pix", n);
    check("frame_cnt_frm", frame_cnt, 32'(m_frame));

    palette = 0;
    @(negedge clk) drive(1, 1, 1, 420, 250);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_vid", {vid.de_out, vid.hsync_out, vid.vsync_out, vid.r_out, vid.g_out, vid.b_out},
          9'b0_1_1_000000);
    check("midrst_frame", frame_cnt, 0);
    check("midrst_phase", phase, 0);
    rst_n = 1'b1;
    m_frame = 0; m_phase = 0; m_dn = 0; m_vs_prev = 1'b1;
    repeat (2) @(negedge clk);
    check("resume_early", vid.de_out, 0);
    @(negedge clk);
    check("resume_pix", {vid.de_out, vid.r_out, vid.g_out, vid.b_out}, {1'b1, 6'b11_10_00});
    drive(0, 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
